// File: rtl/adder_eval_pkg.sv
// Shared defaults and width helpers for the approximate-adder error monitor.
package adder_eval_pkg;
    localparam int N_DEF       = 16;
    localparam int LOG_WIN_DEF = 8;

    // ED needs one extra bit because the exact sum keeps its carry-out.
    function automatic int ed_w(input int n);
        return n + 1;
    endfunction

    function automatic int sum_w(input int n, input int log_win);
        return n + 1 + log_win;
    endfunction

    function automatic int cnt_w(input int log_win);
        return log_win + 1;
    endfunction
endpackage

// File: rtl/err_distance.sv
// Combinational error distance between the exact N+1-bit sum and the N-bit approximate sum.
module err_distance #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] approx_sum,
    output logic [N:0]   ed,
    output logic         err
);
    logic [N:0] exact;
    logic [N:0] apx;

    always_comb begin
        exact = {1'b0, a} + {1'b0, b};
        apx   = {1'b0, approx_sum};
        ed    = (exact >= apx) ? (exact - apx) : (apx - exact);
        err   = |ed;
    end
endmodule

// File: rtl/adder_error_monitor.sv
// Windowed error statistics (error count, ED sum, ED max) for an approximate adder.
module adder_error_monitor
    import adder_eval_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int LOG_WIN = LOG_WIN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [N-1:0]         approx_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG_WIN:0]     err_cnt,
    output logic [N+LOG_WIN:0]   ed_sum,
    output logic [N:0]           ed_max
);
    localparam int ED_W  = ed_w(N);
    localparam int SUM_W = sum_w(N, LOG_WIN);
    localparam int CNT_W = cnt_w(LOG_WIN);

    logic [ED_W-1:0]    ed;
    logic               err;

    logic               rdy_q, rdy_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ED_W-1:0]    s1_ed_q, s1_ed_d;
    logic               s1_err_q, s1_err_d;
    logic [SUM_W-1:0]   acc_sum_q, acc_sum_d;
    logic [CNT_W-1:0]   acc_err_q, acc_err_d;
    logic [ED_W-1:0]    acc_max_q, acc_max_d;
    logic [LOG_WIN-1:0] cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]   ed_sum_q, ed_sum_d;
    logic [ED_W-1:0]    ed_max_q, ed_max_d;

    logic               accept;
    logic [SUM_W-1:0]   sum_nxt;
    logic [CNT_W-1:0]   err_nxt;
    logic [ED_W-1:0]    max_nxt;

    err_distance #(.N(N)) u_err_distance (
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .ed         (ed),
        .err        (err)
    );

    // rdy_q acts as the reset-release qualifier: low until the first clock after rst_n rises.
    assign in_ready  = rdy_q && !out_valid_q && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;
    assign ed_sum    = ed_sum_q;
    assign ed_max    = ed_max_q;

    always_comb begin
        sum_nxt = acc_sum_q + SUM_W'(s1_ed_q);
        err_nxt = acc_err_q + CNT_W'(s1_err_q);
        max_nxt = (s1_ed_q > acc_max_q) ? s1_ed_q : acc_max_q;
    end

    always_comb begin
        rdy_d       = 1'b1;
        s1_valid_d  = accept;
        s1_ed_d     = ed;
        s1_err_d    = err;
        acc_sum_d   = acc_sum_q;
        acc_err_d   = acc_err_q;
        acc_max_d   = acc_max_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        err_cnt_d   = err_cnt_q;
        ed_sum_d    = ed_sum_q;
        ed_max_d    = ed_max_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (clear) begin
            s1_valid_d = 1'b0;
            acc_sum_d  = '0;
            acc_err_d  = '0;
            acc_max_d  = '0;
            cnt_d      = '0;
        end else if (s1_valid_q) begin
            if (cnt_q == '1) begin
                // Last sample of the window: publish totals and restart accumulation.
                err_cnt_d   = err_nxt;
                ed_sum_d    = sum_nxt;
                ed_max_d    = max_nxt;
                out_valid_d = 1'b1;
                acc_sum_d   = '0;
                acc_err_d   = '0;
                acc_max_d   = '0;
                cnt_d       = '0;
            end else begin
                acc_sum_d = sum_nxt;
                acc_err_d = err_nxt;
                acc_max_d = max_nxt;
                cnt_d     = cnt_q + LOG_WIN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ed_q     <= '0;
            s1_err_q    <= 1'b0;
            acc_sum_q   <= '0;
            acc_err_q   <= '0;
            acc_max_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
        end else begin
            rdy_q       <= rdy_d;
            s1_valid_q  <= s1_valid_d;
            s1_ed_q     <= s1_ed_d;
            s1_err_q    <= s1_err_d;
            acc_sum_q   <= acc_sum_d;
            acc_err_q   <= acc_err_d;
            acc_max_q   <= acc_max_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
            ed_sum_q    <= ed_sum_d;
            ed_max_q    <= ed_max_d;
        end
    end
endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed and randomized checks of adder_error_monitor against a window-level reference model.
module tb_adder_error_monitor;
    localparam int N = 16;
    localparam int LW = 2;
    localparam int WIN = 4;

    logic clk, rst_n, clear, in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] a, b, approx_sum;
    logic [LW:0] err_cnt;
    logic [N+LW:0] ed_sum;
    logic [N:0] ed_max;

    int compared = 0;
    int mismatched = 0;
    bit rnd_ready = 0;

    typedef struct { int err; int sum; int max; } res_t;
    res_t exp_q[$];
    int pend[$];
    bit acc_s, clr_s;

    adder_error_monitor #(.N(N), .LOG_WIN(LW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_sum(approx_sum), .out_valid(out_valid), .out_ready(out_ready),
        .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ed_of(input int ia, input int ib, input int iap);
        int d;
        d = ia + ib - iap;
        return (d < 0) ? -d : d;
    endfunction

    // Reference model: collect accepted EDs, summarise each full window with plain arithmetic.
    always @(negedge clk) begin
        acc_s = in_valid && in_ready;
        clr_s = clear;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
        end else if (clr_s) begin
            pend.delete();
        end else if (acc_s) begin
            pend.push_back(ed_of(int'(a), int'(b), int'(approx_sum)));
            if (pend.size() == WIN) begin
                res_t r;
                r = '{0, 0, 0};
                foreach (pend[i]) begin
                    if (pend[i] != 0) r.err++;
                    r.sum += pend[i];
                    if (pend[i] > r.max) r.max = pend[i];
                end
                exp_q.push_back(r);
                pend.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("model_err_cnt", err_cnt, r.err);
                check("model_ed_sum", ed_sum, r.sum);
                check("model_ed_max", ed_max, r.max);
            end
        end
    end

    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic [N-1:0] vap);
        logic r;
        a = va; b = vb; approx_sum = vap; in_valid = 1;
        for (int i = 0; i < 60; i++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            r = in_ready;
            if (rnd_ready) check("in_ready_rule", in_ready, !out_valid);
            @(posedge clk); #1;
            if (r) begin
                in_valid = 0;
                return;
            end
        end
        in_valid = 0;
        check("send_timeout", 0, 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(tag, out_valid, 1);
    endtask

    task automatic consume();
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
    endtask

    initial begin
        logic stable;
        logic [LW:0] c_err;
        logic [N+LW:0] c_sum;
        logic [N:0] c_max;

        rst_n = 0; clear = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; approx_sum = 0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ed_sum", ed_sum, 0);
        check("rst_ed_max", ed_max, 0);
        #20 rst_n = 1;
        #1 check("rdy_before_clk", in_ready, 0);
        @(posedge clk); #1 check("rdy_after_clk", in_ready, 1);

        // 1: exact samples, latency
        repeat (WIN) send(16'h1234, 16'h5678, 16'h68AC);
        @(negedge clk) check("t1_lat_early", out_valid, 0);
        @(negedge clk) check("t1_lat", out_valid, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_ed_sum", ed_sum, 0);
        check("t1_ed_max", ed_max, 0);
        consume();

        // 2: lost carry
        send(16'hFFFF, 16'h0001, 16'h0000);
        repeat (3) send(16'h1111, 16'h2222, 16'h3333);
        wait_valid("t2_valid");
        check("t2_err_cnt", err_cnt, 1);
        check("t2_ed_sum", ed_sum, 32'h10000);
        check("t2_ed_max", ed_max, 32'h10000);
        consume();

        // 3: approx above exact
        repeat (WIN) send(16'h1234, 16'h5678, 16'h68B0);
        wait_valid("t3_valid");
        check("t3_err_cnt", err_cnt, 4);
        check("t3_ed_sum", ed_sum, 16);
        check("t3_ed_max", ed_max, 4);
        consume();

        // 4: backpressure, trailing S1 sample rolls into next window
        repeat (WIN) send(16'h0010, 16'h0020, 16'h0030);
        send(16'h0001, 16'h0001, 16'h0003);
        wait_valid("t4_valid");
        c_err = err_cnt; c_sum = ed_sum; c_max = ed_max; stable = 1;
        check("t4_err_cnt", c_err, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || err_cnt !== c_err || ed_sum !== c_sum || ed_max !== c_max) stable = 0;
            check("t4_in_ready_low", in_ready, 0);
        end
        check("t4_stable", stable, 1);
        consume();
        repeat (3) send(16'h0001, 16'h0001, 16'h0003);
        wait_valid("t4b_valid");
        check("t4b_err_cnt", err_cnt, 4);
        check("t4b_ed_sum", ed_sum, 4);
        check("t4b_ed_max", ed_max, 1);
        consume();

        // 5: clear discards partial window
        repeat (2) send(16'h0002, 16'h0002, 16'h0006);
        clear = 1;
        @(negedge clk) check("t5_clear_rdy", in_ready, 0);
        @(posedge clk); #1 clear = 0;
        repeat (WIN) send(16'h0000, 16'h0000, 16'h0001);
        wait_valid("t5_valid");
        check("t5_err_cnt", err_cnt, 4);
        check("t5_ed_sum", ed_sum, 4);
        check("t5_ed_max", ed_max, 1);
        consume();

        // 6: async reset mid-window
        repeat (2) send(16'h0000, 16'h0000, 16'h0007);
        @(posedge clk); #3 rst_n = 0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_ed_sum", ed_sum, 0);
        check("t6_ed_max", ed_max, 0);
        check("t6_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1 check("t6_rdy", in_ready, 1);
        repeat (WIN) send(16'h0000, 16'h0000, 16'h0003);
        wait_valid("t6_valid");
        check("t6b_err_cnt", err_cnt, 4);
        check("t6b_ed_sum", ed_sum, 12);
        check("t6b_ed_max", ed_max, 3);
        consume();

        // Random samples with random gaps and backpressure
        rnd_ready = 1;
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] ra, rb, rs;
            int mode;
            mode = $urandom_range(0, 3);
            ra = N'($urandom);
            rb = N'($urandom);
            if (mode == 3) begin ra = 16'hFFFF; rb = N'($urandom_range(0, 3)); end
            rs = ra + rb;
            if (mode == 1) rs = rs + N'($urandom_range(0, 31)) - 16'd16;
            if (mode == 2) rs = N'($urandom);
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            send(ra, rb, rs);
        end
        rnd_ready = 0;
        out_ready = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_results", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
        check("drain_pending", pend.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
